// File: rtl/multi_cycle_controller_if.sv
// Control bus between the multi-cycle sequencer and the shared datapath.
// master = sequencer (drives control fields), slave = datapath (drives IR fields and flags).
interface multi_cycle_controller_if;
  logic [5:0] operator;
  logic [5:0] special;
  logic       aluZero;
  logic       memReady;
  logic       resume;

  logic       memRequest;
  logic       irWrite;
  logic       pcWriteEnable;
  logic [1:0] pcSource;
  logic [3:0] aluOperator;
  logic [1:0] aluX;
  logic [2:0] aluY;
  logic       regWriteEnable;
  logic [1:0] regWriteDestinationControl;
  logic       regWriteSourceControl;
  logic       ramWrite;
  logic       halted;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  operator, special, aluZero, memReady, resume,
    output memRequest, irWrite, pcWriteEnable, pcSource, aluOperator, aluX, aluY,
           regWriteEnable, regWriteDestinationControl, regWriteSourceControl,
           ramWrite, halted, illegal, state
  );

  modport slave (
    output operator, special, aluZero, memReady, resume,
    input  memRequest, irWrite, pcWriteEnable, pcSource, aluOperator, aluX, aluY,
           regWriteEnable, regWriteDestinationControl, regWriteSourceControl,
           ramWrite, halted, illegal, state
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// MIPS-subset multi-cycle sequencer: 2-5 cycles per instruction plus one per memory wait cycle.
// Stalls in FETCH/MEMORY until memReady; strobes decode from registered state, qualified by memReady/aluZero.
module multi_cycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multi_cycle_controller_if.master   bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ALUR, C_SHIFT, C_JR, C_SYSCALL, C_IMMS, C_IMMZ,
    C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILLEGAL
  } instClass_t;

  state_t     stateQ;
  logic       illegalQ;
  instClass_t instClass;
  logic [3:0] decodedAluOp;

  // Instruction class and ALU operation from the latched IR fields.
  always_comb begin
    instClass    = C_ILLEGAL;
    decodedAluOp = 4'd0;
    case (bus.operator)
      6'h00: begin
        case (bus.special)
          6'h20, 6'h21: begin instClass = C_ALUR;  decodedAluOp = 4'd4;  end
          6'h22:        begin instClass = C_ALUR;  decodedAluOp = 4'd5;  end
          6'h24:        begin instClass = C_ALUR;  decodedAluOp = 4'd6;  end
          6'h25:        begin instClass = C_ALUR;  decodedAluOp = 4'd7;  end
          6'h27:        begin instClass = C_ALUR;  decodedAluOp = 4'd8;  end
          6'h2A:        begin instClass = C_ALUR;  decodedAluOp = 4'd9;  end
          6'h2B:        begin instClass = C_ALUR;  decodedAluOp = 4'd10; end
          6'h00:        begin instClass = C_SHIFT; decodedAluOp = 4'd0;  end
          6'h02:        begin instClass = C_SHIFT; decodedAluOp = 4'd2;  end
          6'h03:        begin instClass = C_SHIFT; decodedAluOp = 4'd1;  end
          6'h08:        instClass = C_JR;
          6'h0C:        instClass = C_SYSCALL;
          default:      instClass = C_ILLEGAL;
        endcase
      end
      6'h08, 6'h09: begin instClass = C_IMMS; decodedAluOp = 4'd4; end
      6'h0A:        begin instClass = C_IMMS; decodedAluOp = 4'd9; end
      6'h0C:        begin instClass = C_IMMZ; decodedAluOp = 4'd6; end
      6'h0D:        begin instClass = C_IMMZ; decodedAluOp = 4'd7; end
      6'h23:        begin instClass = C_LW;   decodedAluOp = 4'd4; end
      6'h2B:        begin instClass = C_SW;   decodedAluOp = 4'd4; end
      6'h04:        begin instClass = C_BEQ;  decodedAluOp = 4'd5; end
      6'h05:        begin instClass = C_BNE;  decodedAluOp = 4'd5; end
      6'h02:        instClass = C_J;
      6'h03:        begin instClass = C_JAL;  decodedAluOp = 4'd4; end
      default:      instClass = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= FETCH;
      illegalQ <= 1'b0;
    end else begin
      case (stateQ)
        FETCH: begin
          if (bus.memReady) stateQ <= DECODE;
        end
        DECODE: begin
          case (instClass)
            C_J, C_JR: stateQ <= FETCH;
            C_SYSCALL: begin
              stateQ   <= HALT;
              illegalQ <= 1'b0;
            end
            C_ILLEGAL: begin
              if (HALT_ON_ILLEGAL) begin
                stateQ   <= HALT;
                illegalQ <= 1'b1;
              end else begin
                stateQ <= FETCH;
              end
            end
            default: stateQ <= EXECUTE;
          endcase
        end
        EXECUTE: begin
          case (instClass)
            C_BEQ, C_BNE: stateQ <= FETCH;
            C_LW, C_SW:   stateQ <= MEMORY;
            default:      stateQ <= WRITEBACK;
          endcase
        end
        MEMORY: begin
          if (bus.memReady) stateQ <= (instClass == C_LW) ? WRITEBACK : FETCH;
        end
        WRITEBACK: stateQ <= FETCH;
        HALT: begin
          if (bus.resume) begin
            stateQ   <= FETCH;
            illegalQ <= 1'b0;
          end
        end
        default: stateQ <= FETCH;
      endcase
    end
  end

  logic       memRequestC;
  logic       irWriteC;
  logic       pcWriteC;
  logic [1:0] pcSourceC;
  logic [3:0] aluOpC;
  logic [1:0] aluXC;
  logic [2:0] aluYC;
  logic       regWriteC;
  logic [1:0] destC;
  logic       srcC;
  logic       ramWriteC;

  // Everything is forced low while reset is held so nothing strobes mid-access.
  always_comb begin
    memRequestC = 1'b0;
    irWriteC    = 1'b0;
    pcWriteC    = 1'b0;
    pcSourceC   = 2'd0;
    aluOpC      = 4'd0;
    aluXC       = 2'd0;
    aluYC       = 3'd0;
    regWriteC   = 1'b0;
    destC       = 2'd0;
    srcC        = 1'b0;
    ramWriteC   = 1'b0;
    if (rst_n) begin
      // ALU fields stay put from EXECUTE through MEMORY/WRITEBACK.
      if (stateQ == EXECUTE || stateQ == MEMORY || stateQ == WRITEBACK) begin
        aluOpC = decodedAluOp;
        case (instClass)
          C_SHIFT:           begin aluXC = 2'd1; aluYC = 3'd3; end
          C_IMMS, C_LW, C_SW: aluYC = 3'd1;
          C_IMMZ:            aluYC = 3'd2;
          C_JAL:             begin aluXC = 2'd2; aluYC = 3'd4; end
          default:           ;
        endcase
      end
      case (stateQ)
        FETCH: begin
          memRequestC = 1'b1;
          if (bus.memReady) begin
            irWriteC = 1'b1;
            pcWriteC = 1'b1;
          end
        end
        DECODE: begin
          if (instClass == C_J) begin
            pcWriteC  = 1'b1;
            pcSourceC = 2'd2;
          end else if (instClass == C_JR) begin
            pcWriteC  = 1'b1;
            pcSourceC = 2'd3;
          end
        end
        EXECUTE: begin
          if ((instClass == C_BEQ && bus.aluZero) || (instClass == C_BNE && !bus.aluZero)) begin
            pcWriteC  = 1'b1;
            pcSourceC = 2'd1;
          end else if (instClass == C_JAL) begin
            pcWriteC  = 1'b1;
            pcSourceC = 2'd2;
          end
        end
        MEMORY: begin
          memRequestC = 1'b1;
          ramWriteC   = (instClass == C_SW);
        end
        WRITEBACK: begin
          regWriteC = 1'b1;
          if (instClass == C_JAL)                              destC = 2'd2;
          else if (instClass == C_ALUR || instClass == C_SHIFT) destC = 2'd1;
          srcC = (instClass == C_LW);
        end
        default: ;
      endcase
    end
  end

  assign bus.memRequest                 = memRequestC;
  assign bus.irWrite                    = irWriteC;
  assign bus.pcWriteEnable              = pcWriteC;
  assign bus.pcSource                   = pcSourceC;
  assign bus.aluOperator                = aluOpC;
  assign bus.aluX                       = aluXC;
  assign bus.aluY                       = aluYC;
  assign bus.regWriteEnable             = regWriteC;
  assign bus.regWriteDestinationControl = destC;
  assign bus.regWriteSourceControl      = srcC;
  assign bus.ramWrite                   = ramWriteC;
  assign bus.halted                     = (stateQ == HALT);
  assign bus.illegal                    = illegalQ;
  assign bus.state                      = stateQ;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed vector bench for multi_cycle_controller: one table row per clock cycle plus reset corner sequences.
module tb_multi_cycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_controller_if bus ();

  multi_cycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       memReq;
    logic       irW;
    logic       pcW;
    logic [1:0] pcSrc;
    logic [3:0] aluOp;
    logic [1:0] x;
    logic [2:0] y;
    logic       regW;
    logic [1:0] dst;
    logic       src;
    logic       ramW;
    logic       halted;
    logic       ill;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] sp;
    logic       zero;
    logic       rdy;
    logic       res;
    outs_t      exp;
  } vec_t;

  outs_t dutOuts;
  assign dutOuts = {bus.state, bus.memRequest, bus.irWrite, bus.pcWriteEnable, bus.pcSource,
                    bus.aluOperator, bus.aluX, bus.aluY, bus.regWriteEnable,
                    bus.regWriteDestinationControl, bus.regWriteSourceControl,
                    bus.ramWrite, bus.halted, bus.illegal};

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  function automatic outs_t e(input logic [2:0] st, input logic mr, input logic irw, input logic pcw,
                              input logic [1:0] pcs, input logic [3:0] aop, input logic [1:0] x,
                              input logic [2:0] y, input logic rw, input logic [1:0] dst,
                              input logic src, input logic ramw, input logic ill);
    outs_t r;
    r = {st, mr, irw, pcw, pcs, aop, x, y, rw, dst, src, ramw, (st == 3'd5), ill};
    return r;
  endfunction

  task automatic add(input string n, input logic [5:0] op, input logic [5:0] sp, input logic zero,
                     input logic rdy, input logic res, input outs_t ex);
    vec_t v;
    v.name = n; v.op = op; v.sp = sp; v.zero = zero; v.rdy = rdy; v.res = res; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input outs_t got, input outs_t ex);
    testsRun++;
    if (got !== ex) begin
      testsFailed++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", n, got, ex, $time);
    end
  endtask

  outs_t fDone, fWait, dec, zeroOuts;

  initial begin
    fDone    = e(0,1,1,1,0,0,0,0,0,0,0,0,0);
    fWait    = e(0,1,0,0,0,0,0,0,0,0,0,0,0);
    dec      = e(1,0,0,0,0,0,0,0,0,0,0,0,0);
    zeroOuts = e(0,0,0,0,0,0,0,0,0,0,0,0,0);

    // addu: 0,1,2,4 then back to 0
    add("addu_f",  6'h00, 6'h21, 0, 1, 0, fDone);
    add("addu_d",  6'h00, 6'h21, 0, 1, 0, dec);
    add("addu_e",  6'h00, 6'h21, 0, 1, 0, e(2,0,0,0,0,4,0,0,0,0,0,0,0));
    add("addu_wb", 6'h00, 6'h21, 0, 1, 0, e(4,0,0,0,0,4,0,0,1,1,0,0,0));
    // lw with two wait cycles in FETCH and MEMORY: 9 cycles
    add("lw_fw0",  6'h23, 6'h00, 0, 0, 0, fWait);
    add("lw_fw1",  6'h23, 6'h00, 0, 0, 1, fWait);
    add("lw_f",    6'h23, 6'h00, 0, 1, 0, fDone);
    add("lw_d",    6'h23, 6'h00, 0, 1, 0, dec);
    add("lw_e",    6'h23, 6'h00, 0, 0, 0, e(2,0,0,0,0,4,0,1,0,0,0,0,0));
    add("lw_mw0",  6'h23, 6'h00, 0, 0, 0, e(3,1,0,0,0,4,0,1,0,0,0,0,0));
    add("lw_mw1",  6'h23, 6'h00, 0, 0, 0, e(3,1,0,0,0,4,0,1,0,0,0,0,0));
    add("lw_m",    6'h23, 6'h00, 0, 1, 0, e(3,1,0,0,0,4,0,1,0,0,0,0,0));
    add("lw_wb",   6'h23, 6'h00, 0, 1, 0, e(4,0,0,0,0,4,0,1,1,0,1,0,0));
    // beq taken / not taken, bne inverse
    add("beqT_f",  6'h04, 6'h00, 1, 1, 0, fDone);
    add("beqT_d",  6'h04, 6'h00, 1, 1, 0, dec);
    add("beqT_e",  6'h04, 6'h00, 1, 1, 0, e(2,0,0,1,1,5,0,0,0,0,0,0,0));
    add("beqN_f",  6'h04, 6'h00, 0, 1, 0, fDone);
    add("beqN_d",  6'h04, 6'h00, 0, 1, 0, dec);
    add("beqN_e",  6'h04, 6'h00, 0, 1, 0, e(2,0,0,0,0,5,0,0,0,0,0,0,0));
    add("bneT_f",  6'h05, 6'h00, 0, 1, 0, fDone);
    add("bneT_d",  6'h05, 6'h00, 0, 1, 0, dec);
    add("bneT_e",  6'h05, 6'h00, 0, 1, 0, e(2,0,0,1,1,5,0,0,0,0,0,0,0));
    add("bneN_f",  6'h05, 6'h00, 1, 1, 0, fDone);
    add("bneN_d",  6'h05, 6'h00, 1, 1, 0, dec);
    add("bneN_e",  6'h05, 6'h00, 1, 1, 0, e(2,0,0,0,0,5,0,0,0,0,0,0,0));
    // sw: ramWrite held through the wait cycle
    add("sw_f",    6'h2B, 6'h00, 0, 1, 0, fDone);
    add("sw_d",    6'h2B, 6'h00, 0, 1, 0, dec);
    add("sw_e",    6'h2B, 6'h00, 0, 1, 0, e(2,0,0,0,0,4,0,1,0,0,0,0,0));
    add("sw_mw",   6'h2B, 6'h00, 0, 0, 0, e(3,1,0,0,0,4,0,1,0,0,0,1,0));
    add("sw_m",    6'h2B, 6'h00, 0, 1, 0, e(3,1,0,0,0,4,0,1,0,0,0,1,0));
    // jal, j, jr
    add("jal_f",   6'h03, 6'h00, 0, 1, 0, fDone);
    add("jal_d",   6'h03, 6'h00, 0, 1, 0, dec);
    add("jal_e",   6'h03, 6'h00, 0, 1, 0, e(2,0,0,1,2,4,2,4,0,0,0,0,0));
    add("jal_wb",  6'h03, 6'h00, 0, 1, 0, e(4,0,0,0,0,4,2,4,1,2,0,0,0));
    add("j_f",     6'h02, 6'h00, 0, 1, 0, fDone);
    add("j_d",     6'h02, 6'h00, 0, 1, 0, e(1,0,0,1,2,0,0,0,0,0,0,0,0));
    add("jr_f",    6'h00, 6'h08, 0, 1, 0, fDone);
    add("jr_d",    6'h00, 6'h08, 0, 1, 0, e(1,0,0,1,3,0,0,0,0,0,0,0,0));
    // sll (shift operand routing), ori (zero-ext imm, rt dest)
    add("sll_f",   6'h00, 6'h00, 0, 1, 0, fDone);
    add("sll_d",   6'h00, 6'h00, 0, 1, 0, dec);
    add("sll_e",   6'h00, 6'h00, 0, 1, 0, e(2,0,0,0,0,0,1,3,0,0,0,0,0));
    add("sll_wb",  6'h00, 6'h00, 0, 1, 0, e(4,0,0,0,0,0,1,3,1,1,0,0,0));
    add("ori_f",   6'h0D, 6'h00, 0, 1, 0, fDone);
    add("ori_d",   6'h0D, 6'h00, 0, 1, 0, dec);
    add("ori_e",   6'h0D, 6'h00, 0, 1, 0, e(2,0,0,0,0,7,0,2,0,0,0,0,0));
    add("ori_wb",  6'h0D, 6'h00, 0, 1, 0, e(4,0,0,0,0,7,0,2,1,0,0,0,0));
    // syscall: resume on the entry cycle is ignored, 20 quiet HALT cycles
    add("sys_f",   6'h00, 6'h0C, 1, 1, 0, fDone);
    add("sys_d",   6'h00, 6'h0C, 1, 1, 1, dec);
    for (int i = 0; i < 20; i++)
      add($sformatf("sys_h%0d", i), 6'h00, 6'h0C, 1, 1, 0, e(5,0,0,0,0,0,0,0,0,0,0,0,0));
    add("sys_res", 6'h00, 6'h0C, 1, 1, 1, e(5,0,0,0,0,0,0,0,0,0,0,0,0));
    add("sys_f2",  6'h00, 6'h0C, 1, 0, 0, fWait);
    // illegal operator: sticky flag until resume
    add("ill_f",   6'h3F, 6'h00, 0, 1, 0, fDone);
    add("ill_d",   6'h3F, 6'h00, 0, 1, 0, dec);
    add("ill_h",   6'h3F, 6'h00, 0, 1, 0, e(5,0,0,0,0,0,0,0,0,0,0,0,1));
    add("ill_res", 6'h3F, 6'h00, 0, 1, 1, e(5,0,0,0,0,0,0,0,0,0,0,0,1));
    add("ill_f2",  6'h3F, 6'h00, 0, 0, 0, fWait);

    bus.operator = 6'h00; bus.special = 6'h00; bus.aluZero = 1'b0;
    bus.memReady = 1'b1;  bus.resume  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", dutOuts, zeroOuts);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.operator = vecs[i].op;
      bus.special  = vecs[i].sp;
      bus.aluZero  = vecs[i].zero;
      bus.memReady = vecs[i].rdy;
      bus.resume   = vecs[i].res;
      @(negedge clk);
      chk(vecs[i].name, dutOuts, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-MEMORY of a store
    bus.operator = 6'h2B; bus.special = 6'h00; bus.resume = 1'b0; bus.memReady = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.memReady = 1'b0;
    @(negedge clk);
    chk("rst_pre_mem", dutOuts, e(3,1,0,0,0,4,0,1,0,0,0,1,0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", dutOuts, zeroOuts);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", dutOuts, fWait);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
